// File: rtl/noc_buf_pkg.sv
// Shared constants, types and width helpers for the VC flit buffer.
package noc_buf_pkg;

    localparam int NB_WIDTH  = 64;
    localparam int NB_DEPTH  = 4;
    localparam int NB_NUM_VC = 2;

    // Width of a free-slot counter that must hold the value DEPTH itself.
    function automatic int calc_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // VC index width; a single-VC buffer still gets a 1-bit index.
    function automatic int calc_vc_w(input int num_vc);
        return (num_vc > 1) ? $clog2(num_vc) : 1;
    endfunction

    localparam int NB_VC_W = calc_vc_w(NB_NUM_VC);

    typedef logic [NB_WIDTH-1:0] flit_t;
    typedef logic [NB_VC_W-1:0]  vc_id_t;

endpackage

// File: rtl/vc_fifo_slice.sv
// Single-VC FIFO. Push/pop arrive already qualified by the top level.
// The free-slot counter, not the pointers, tells full from empty.
module vc_fifo_slice
    import noc_buf_pkg::*;
#(
    parameter int   WIDTH = NB_WIDTH,
    parameter int   DEPTH = NB_DEPTH,
    localparam int  CNT_W = calc_cnt_w(DEPTH),
    localparam int  PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_en,
    input  logic             pop_en,
    input  logic [WIDTH-1:0] bf_in,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] em_pl
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_em_pl;

    // Storage, pointers and free-slot count; push+pop together leaves the count alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_em_pl  <= CNT_W'(DEPTH);
        end else begin
            if (push_en) begin
                r_mem[r_wr_ptr] <= bf_in;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (pop_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   r_em_pl <= r_em_pl - CNT_W'(1);
                2'b01:   r_em_pl <= r_em_pl + CNT_W'(1);
                default: r_em_pl <= r_em_pl;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign em_pl = r_em_pl;

endmodule

// File: rtl/vc_flit_buffer.sv
// Multi-VC router input buffer: shared write and read ports over NUM_VC FIFOs,
// per-VC free-slot report and one credit returned per popped flit.
// Optional macro VC_FLIT_BUFFER_ERR_EN adds sticky err_flags
// (bit0 dropped push, bit1 ignored pop).
module vc_flit_buffer
    import noc_buf_pkg::*;
#(
    parameter int   WIDTH  = NB_WIDTH,
    parameter int   DEPTH  = NB_DEPTH,
    parameter int   NUM_VC = NB_NUM_VC,
    localparam int  VC_W   = calc_vc_w(NUM_VC),
    localparam int  CNT_W  = calc_cnt_w(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [VC_W-1:0]         push_vc,
    input  logic [WIDTH-1:0]        bf_in,
    input  logic                    pop,
    input  logic [VC_W-1:0]         rd_vc,
    output logic [WIDTH-1:0]        bf_out,
    output logic [NUM_VC*CNT_W-1:0] em_pl,
    output logic [NUM_VC-1:0]       vc_empty,
    output logic                    cr_valid,
    output logic [VC_W-1:0]         cr_vc
`ifdef VC_FLIT_BUFFER_ERR_EN
    ,
    output logic [1:0]              err_flags
`endif
);

    logic [WIDTH-1:0] w_head  [NUM_VC];
    logic [CNT_W-1:0] w_em_pl [NUM_VC];
    logic             w_push_room;
    logic             w_rd_nonempty;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic             r_cr_valid;
    logic [VC_W-1:0]  r_cr_vc;

    // Select the addressed VC's status and head flit; out-of-range indices see nothing.
    always_comb begin
        w_push_room   = 1'b0;
        w_rd_nonempty = 1'b0;
        bf_out        = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (push_vc == VC_W'(v)) begin
                w_push_room = (w_em_pl[v] != '0);
            end
            if (rd_vc == VC_W'(v)) begin
                w_rd_nonempty = !vc_empty[v];
                bf_out        = w_head[v];
            end
        end
    end

    // A full VC still takes a push when the same cycle pops it: the write reuses the vacated slot.
    assign w_pop_ok  = pop && w_rd_nonempty;
    assign w_push_ok = push && (w_push_room || (w_pop_ok && (rd_vc == push_vc)));

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        vc_fifo_slice #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_slice (
            .clk     (clk),
            .reset   (reset),
            .push_en (w_push_ok && (push_vc == VC_W'(v))),
            .pop_en  (w_pop_ok && (rd_vc == VC_W'(v))),
            .bf_in   (bf_in),
            .head    (w_head[v]),
            .em_pl   (w_em_pl[v])
        );
        assign em_pl[v*CNT_W +: CNT_W] = w_em_pl[v];
        assign vc_empty[v]             = (w_em_pl[v] == CNT_W'(DEPTH));
    end

    // One credit per accepted pop, presented for the cycle after the pop edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cr_valid <= 1'b0;
            r_cr_vc    <= '0;
        end else begin
            r_cr_valid <= w_pop_ok;
            r_cr_vc    <= w_pop_ok ? rd_vc : '0;
        end
    end

    assign cr_valid = r_cr_valid;
    assign cr_vc    = r_cr_vc;

`ifdef VC_FLIT_BUFFER_ERR_EN
    logic [1:0] r_err;

    // Sticky overflow/underflow flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= '0;
        end else begin
            r_err <= r_err | {pop && !w_pop_ok, push && !w_push_ok};
        end
    end

    assign err_flags = r_err;
`endif

endmodule

// File: tb/tb_vc_flit_buffer.sv
// Scoreboard bench for vc_flit_buffer: a queue-per-VC reference model predicts
// each cycle's visible outputs, a negedge monitor compares them.
module tb_vc_flit_buffer;

    localparam int W  = 64;
    localparam int D  = 4;
    localparam int NV = 2;
    localparam int VW = 1;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              push;
    logic [VW-1:0]     push_vc;
    logic [W-1:0]      bf_in;
    logic              pop;
    logic [VW-1:0]     rd_vc;
    logic [W-1:0]      bf_out;
    logic [NV*CW-1:0]  em_pl;
    logic [NV-1:0]     vc_empty;
    logic              cr_valid;
    logic [VW-1:0]     cr_vc;
`ifdef VC_FLIT_BUFFER_ERR_EN
    logic [1:0]        err_flags;
`endif

    always #5 clk = ~clk;

    vc_flit_buffer #(.WIDTH(W), .DEPTH(D), .NUM_VC(NV)) dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_vc  (push_vc),
        .bf_in    (bf_in),
        .pop      (pop),
        .rd_vc    (rd_vc),
        .bf_out   (bf_out),
        .em_pl    (em_pl),
        .vc_empty (vc_empty),
        .cr_valid (cr_valid),
        .cr_vc    (cr_vc)
`ifdef VC_FLIT_BUFFER_ERR_EN
        ,
        .err_flags(err_flags)
`endif
    );

    typedef struct {
        logic [NV*CW-1:0] em;
        logic [NV-1:0]    emp;
        logic             crv;
        logic [VW-1:0]    crvc;
        logic             chk_bf;
        logic [W-1:0]     bf;
        logic [1:0]       err;
    } rec_t;

    rec_t          sbq[$];
    rec_t          mon_r;
    logic [W-1:0]  mq [NV][$];
    bit            m_fresh [NV];
    logic          m_crv;
    logic [VW-1:0] m_crvc;
    logic [1:0]    m_err;
    int            n_chk  = 0;
    int            n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            mq[v].delete();
            m_fresh[v] = 1'b1;
        end
        m_crv  = 1'b0;
        m_crvc = '0;
        m_err  = '0;
    endtask

    // Drive one cycle, queue the expected view for it, then advance the model past the edge.
    task automatic cyc(input bit rst, input bit ps, input int pvc, input logic [W-1:0] din,
                       input bit pp, input int rvc);
        rec_t r;
        bit   pop_ok, push_ok;
        @(posedge clk);
        #1;
        reset   = rst;
        push    = ps;
        push_vc = pvc[VW-1:0];
        bf_in   = din;
        pop     = pp;
        rd_vc   = rvc[VW-1:0];
        for (int v = 0; v < NV; v++) begin
            r.em[v*CW +: CW] = CW'(D - mq[v].size());
            r.emp[v]         = (mq[v].size() == 0);
        end
        r.crv  = m_crv;
        r.crvc = m_crvc;
        r.err  = m_err;
        if (mq[rvc].size() > 0) begin
            r.chk_bf = 1'b1;
            r.bf     = mq[rvc][0];
        end else begin
            r.chk_bf = m_fresh[rvc];
            r.bf     = '0;
        end
        sbq.push_back(r);
        if (rst) begin
            model_reset();
        end else begin
            pop_ok  = pp && (mq[rvc].size() > 0);
            push_ok = ps && ((mq[pvc].size() < D) || (pop_ok && rvc == pvc));
            if (pop_ok) void'(mq[rvc].pop_front());
            if (push_ok) begin
                mq[pvc].push_back(din);
                m_fresh[pvc] = 1'b0;
            end
            m_crv  = pop_ok;
            m_crvc = pop_ok ? rvc[VW-1:0] : '0;
            m_err  = m_err | {pp && !pop_ok, ps && !push_ok};
        end
    endtask

    // Monitor: compare the DUT's outputs with the queued expectation for this cycle.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mon_r = sbq.pop_front();
            chk("em_pl", 64'(em_pl), 64'(mon_r.em));
            chk("vc_empty", 64'(vc_empty), 64'(mon_r.emp));
            chk("cr_valid", 64'(cr_valid), 64'(mon_r.crv));
            if (mon_r.crv) chk("cr_vc", 64'(cr_vc), 64'(mon_r.crvc));
            if (mon_r.chk_bf) chk("bf_out", bf_out, mon_r.bf);
`ifdef VC_FLIT_BUFFER_ERR_EN
            chk("err_flags", 64'(err_flags), 64'(mon_r.err));
`endif
        end
    end

    initial begin
        reset   = 1'b1;
        push    = 1'b0;
        push_vc = '0;
        bf_in   = '0;
        pop     = 1'b0;
        rd_vc   = '0;
        model_reset();
        repeat (2) @(posedge clk);

        repeat (2) cyc(0, 0, 0, 0, 0, 0);
        // Fill VC0, then overflow it.
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 64'hA0 + i, 0, 0);
        cyc(0, 1, 0, 64'hA4, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);
        // Full VC0 with simultaneous push and pop.
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 64'hC0 + i, 0, 0);
        cyc(0, 1, 0, 64'hB0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);
        // Push VC1 while popping VC0.
        cyc(0, 1, 0, 64'hD0, 0, 0);
        cyc(0, 1, 0, 64'hD1, 0, 0);
        cyc(0, 1, 1, 64'h11, 1, 0);
        // Drain VC1, then pop it while empty.
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 1);
        // Drain VC0, then push+pop on empty VC0.
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 64'hE0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        // Reset with both VCs half full.
        cyc(0, 1, 0, 64'h20, 0, 0);
        cyc(0, 1, 0, 64'h21, 0, 0);
        cyc(0, 1, 1, 64'h30, 0, 1);
        cyc(0, 1, 1, 64'h31, 0, 1);
        cyc(1, 0, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 1);
        // Pointer wrap on VC1.
        cyc(0, 1, 1, 64'hF0, 0, 1);
        for (int i = 1; i < 10; i++) cyc(0, 1, 1, 64'hF0 + i, 1, 1);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1);
        // Random traffic with occasional reset.
        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 63) == 0,
                ($urandom % 4) != 0,
                $urandom_range(0, NV - 1),
                {$urandom, $urandom},
                ($urandom % 2) != 0,
                $urandom_range(0, NV - 1));
        end
        repeat (2) cyc(0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
